// File: rtl/ureg_pkg.sv
// Shared mode encoding and a width-generic reference next-state function
// for the universal shift register.
package ureg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ASR  = 3'd4,
        MODE_ROL  = 3'd5,
        MODE_ROR  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

    localparam int unsigned MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] q;
        logic             sout;
    } next_t;

    // Operates on the low w bits of a MAX_W container; upper bits stay zero.
    function automatic next_t next_state(input mode_e mode, input logic [MAX_W-1:0] q,
                                         input logic [MAX_W-1:0] di, input logic sin,
                                         input logic sout, input int unsigned w);
        next_t            r;
        logic [MAX_W-1:0] mask;
        logic             msb;
        logic             lsb;
        mask   = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        msb    = q[w-1];
        lsb    = q[0];
        r.q    = q;
        r.sout = sout;
        case (mode)
            MODE_HOLD: ;
            MODE_LOAD: r.q = di & mask;
            MODE_SHL: begin
                r.q    = ((q << 1) | MAX_W'(sin)) & mask;
                r.sout = msb;
            end
            MODE_SHR: begin
                r.q    = (q >> 1) | (MAX_W'(sin) << (w - 1));
                r.sout = lsb;
            end
            MODE_ASR: begin
                r.q    = (q >> 1) | (MAX_W'(msb) << (w - 1));
                r.sout = lsb;
            end
            MODE_ROL: begin
                r.q    = ((q << 1) | MAX_W'(msb)) & mask;
                r.sout = msb;
            end
            MODE_ROR: begin
                r.q    = (q >> 1) | (MAX_W'(lsb) << (w - 1));
                r.sout = lsb;
            end
            MODE_CLR: begin
                r.q    = '0;
                r.sout = 1'b0;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ureg_next.sv
// Combinational next-state mux: one operation per mode on the current q.
module ureg_next
    import ureg_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [2:0]   mode,
    input  logic [W-1:0] q,
    input  logic [W-1:0] di,
    input  logic         sin,
    input  logic         sout,
    output logic [W-1:0] q_next,
    output logic         sout_next
);

    always_comb begin
        q_next    = q;
        sout_next = sout;
        case (mode_e'(mode))
            MODE_HOLD: ;
            MODE_LOAD: q_next = di;
            MODE_SHL: begin
                q_next    = {q[W-2:0], sin};
                sout_next = q[W-1];
            end
            MODE_SHR: begin
                q_next    = {sin, q[W-1:1]};
                sout_next = q[0];
            end
            MODE_ASR: begin
                q_next    = {q[W-1], q[W-1:1]};
                sout_next = q[0];
            end
            MODE_ROL: begin
                q_next    = {q[W-2:0], q[W-1]};
                sout_next = q[W-1];
            end
            MODE_ROR: begin
                q_next    = {q[0], q[W-1:1]};
                sout_next = q[0];
            end
            MODE_CLR: begin
                q_next    = '0;
                sout_next = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ureg_shift.sv
// Universal register: parallel load, logical/arithmetic shift, rotate, clear,
// with clock enable, async active-low reset and a zero flag.
module ureg_shift #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic [W-1:0] di,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic         sout,
    output logic         zero
);

    logic [W-1:0] q_next;
    logic         sout_next;

    ureg_next #(.W(W)) u_next (
        .mode      (mode),
        .q         (q),
        .di        (di),
        .sin       (sin),
        .sout      (sout),
        .q_next    (q_next),
        .sout_next (sout_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RST_VAL;
            sout <= 1'b0;
        end else if (en) begin
            q    <= q_next;
            sout <= sout_next;
        end
    end

    assign zero = (q == '0);

endmodule
